// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibits the bus, issues a request-to-send,
// shifts data/parity/stop on device falling edges, samples the ACK bit, watchdogs the device clock.
//   state     | meaning
//   S_IDLE    | lines released, waiting for start
//   S_INHIBIT | clock held low for T_INH ticks
//   S_REQ     | start bit driven, waiting for first device clock
//   S_SHIFT   | presenting data[1..7], parity, stop on falling edges
//   S_ACK     | waiting for the ACK falling edge
//   S_RELEASE | waiting for both lines idle-high
module ps2_host_tx #(
  parameter int CEFREQ = 8000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int T_INH   = CEFREQ / 10000;
  localparam int T_FIRST = CEFREQ * 15 / 1000;
  localparam int T_EDGE  = CEFREQ / 500;
  localparam int CW      = $clog2(T_FIRST);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_RELEASE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   tmr_q, tmr_d;
  logic [9:0]      shr_q, shr_d;
  logic [3:0]      idx_q, idx_d;
  logic [1:0]      clk_sync_q, dat_sync_q;
  logic            clk_prev_q;
  logic            clk_oe_q, clk_oe_d;
  logic            dat_oe_q, dat_oe_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ack_err_q, ack_err_d;
  logic            timeout_q, timeout_d;
  logic            clk_s, dat_s, fall;

  // Line sampling advances only on ce so edge detection sees consecutive ce samples.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else if (ce) begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];
  assign fall  = clk_prev_q & ~clk_s;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      shr_q     <= '0;
      idx_q     <= '0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      shr_q     <= shr_d;
      idx_q     <= idx_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    shr_d     = shr_q;
    idx_d     = idx_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    timeout_d = timeout_q;
    if (ce) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            // Frame order on the wire: data[0..7], odd parity, stop.
            shr_d     = {1'b1, ~^data, data};
            idx_d     = '0;
            busy_d    = 1'b1;
            ack_err_d = 1'b0;
            timeout_d = 1'b0;
            tmr_d     = CW'(T_INH - 1);
            clk_oe_d  = 1'b1;
            dat_oe_d  = 1'b0;
            state_d   = S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (tmr_q == '0) begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b1;
            tmr_d    = CW'(T_FIRST - 1);
            state_d  = S_REQ;
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end
        S_REQ, S_SHIFT, S_ACK: begin
          if (fall) begin
            tmr_d = CW'(T_EDGE - 1);
            if (state_q == S_ACK) begin
              ack_err_d = dat_s;
              dat_oe_d  = 1'b0;
              state_d   = S_RELEASE;
            end else begin
              dat_oe_d = ~shr_q[0];
              shr_d    = {1'b1, shr_q[9:1]};
              idx_d    = idx_q + 4'd1;
              state_d  = (idx_q == 4'd9) ? S_ACK : S_SHIFT;
            end
          end else if (tmr_q == '0) begin
            clk_oe_d  = 1'b0;
            dat_oe_d  = 1'b0;
            timeout_d = 1'b1;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = S_IDLE;
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end
        S_RELEASE: begin
          if (clk_s && dat_s) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ack_err    = ack_err_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus plus a behavioural PS/2 device; expected
// frames come from a parity/bit-order reference function.
module tb_ps2_host_tx;

  localparam int CEFREQ  = 160000;
  localparam int T_INH   = CEFREQ / 10000;
  localparam int T_FIRST = CEFREQ * 15 / 1000;
  localparam int T_EDGE  = CEFREQ / 500;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ce = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clk_i, ps2_dat_i;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       busy, done, ack_err, timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  assign ps2_clk_i = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_i = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(.CEFREQ(CEFREQ)) dut (
    .clock(clock), .reset(reset), .ce(ce),
    .ps2_clk_i(ps2_clk_i), .ps2_dat_i(ps2_dat_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
    .start(start), .data(data),
    .busy(busy), .done(done), .ack_err(ack_err), .timeout(timeout)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line levels a device sees: [0] start, [8:1] data LSB first, [9] odd parity, [10] stop.
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic kick(input logic [7:0] b);
    data  = b;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_inhibit(input int frz_at, input int frz_len, output int cnt);
    cnt = 0;
    while (ps2_clk_oe === 1'b1 && cnt < T_INH + 200) begin
      cnt++;
      if (frz_len > 0 && cnt == frz_at) ce = 1'b0;
      if (frz_len > 0 && cnt == frz_at + frz_len) ce = 1'b1;
      @(negedge clock);
    end
    ce = 1'b1;
  endtask

  task automatic device(input int n_edges, input int half, input bit ack_low,
                        output logic [10:0] seen);
    seen = '1;
    tick(half);
    seen[0] = ps2_dat_i;
    for (int k = 1; k <= n_edges; k++) begin
      if (k == 11 && ack_low) dev_dat = 1'b0;
      dev_clk = 1'b0;
      tick(half);
      dev_clk = 1'b1;
      if (k <= 10) seen[k] = ps2_dat_i;
      if (k < n_edges) tick(half);
    end
    dev_dat = 1'b1;
  endtask

  task automatic wait_done(input int budget, output bit got, output int n);
    got = 1'b0;
    n = budget;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        got = 1'b1;
        n = i;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input int half, input bit ack_low,
                           input bit hijack, input int frz_len, output logic [10:0] seen);
    int inh, n, base;
    bit got;
    base = done_cnt;
    kick(b);
    check("flags_cleared", {ack_err, timeout}, 2'b00);
    check("busy_set", busy, 1'b1);
    wait_inhibit(3, frz_len, inh);
    check("inhibit_len", inh, T_INH + frz_len);
    check("req_start_drive", ps2_dat_oe, 1'b1);
    if (hijack) begin
      data  = ~b;
      start = 1'b1;
      tick(3);
      start = 1'b0;
      check("busy_hold", busy, 1'b1);
    end
    device(11, half, ack_low, seen);
    wait_done(200, got, n);
    check("done_seen", got, 1'b1);
    check("frame", seen, frame_bits(b));
    check("ack_err", ack_err, !ack_low);
    check("timeout_clear", timeout, 1'b0);
    check("busy_at_done", busy, 1'b0);
    check("lines_released", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    tick(1);
    #1;
    check("done_pulse_width", done, 1'b0);
    check("done_count", done_cnt, base + 1);
  endtask

  initial begin
    #(10 * 200000);
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [10:0] seen;
    int inh, n, base;
    bit got;

    #1;
    check("rst_outputs", {ps2_clk_oe, ps2_dat_oe, busy, done, ack_err, timeout}, 6'b0);
    tick(3);
    reset = 1'b1;
    tick(2);
    check("idle_outputs", {ps2_clk_oe, ps2_dat_oe, busy, done}, 4'b0);

    run_frame(8'hED, 20, 1'b1, 1'b0, 0, seen);
    check("ed_parity", seen[9], 1'b1);
    run_frame(8'h00, 12, 1'b1, 1'b0, 0, seen);
    check("p00_parity", seen[9], 1'b1);
    run_frame(8'h01, 12, 1'b1, 1'b0, 0, seen);
    check("p01_parity", seen[9], 1'b0);

    // Device never clocks: request-phase watchdog.
    kick(8'h3C);
    wait_inhibit(0, 0, inh);
    check("inhibit_len_req_wd", inh, T_INH);
    wait_done(T_FIRST + 100, got, n);
    check("req_wd_done", got, 1'b1);
    check("req_wd_window", (n >= T_FIRST - 2 && n <= T_FIRST + 2), 1'b1);
    check("req_wd_flags", {timeout, ack_err, busy}, 3'b100);
    check("req_wd_lines", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    tick(10);
    check("timeout_hold", timeout, 1'b1);

    // Device stops after 4 edges: edge watchdog.
    kick(8'h5A);
    check("flags_cleared_wd", timeout, 1'b0);
    wait_inhibit(0, 0, inh);
    device(4, 15, 1'b0, seen);
    wait_done(T_EDGE + 100, got, n);
    check("edge_wd_done", got, 1'b1);
    check("edge_wd_window", (n >= T_EDGE - 15 && n <= T_EDGE - 15 + 6), 1'b1);
    check("edge_wd_bits", seen[4:0], frame_bits(8'h5A) & 11'h01F);
    check("edge_wd_flags", {timeout, ack_err, busy}, 3'b100);
    check("edge_wd_lines", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    tick(2);

    // Device leaves data high on the ACK edge.
    run_frame(8'hA7, 10, 1'b0, 1'b0, 0, seen);

    // Start during busy must not disturb the frame or queue a second one.
    run_frame(8'h96, 14, 1'b1, 1'b1, 0, seen);
    tick(T_INH + 20);
    check("no_restart", busy, 1'b0);

    // ce held low in INHIBIT stretches the clock-low period by the frozen ticks.
    run_frame(8'h4B, 16, 1'b1, 1'b0, 10, seen);

    // Reset in the middle of SHIFT.
    kick(8'hC3);
    wait_inhibit(0, 0, inh);
    device(5, 12, 1'b0, seen);
    tick(2);
    base = done_cnt;
    reset = 1'b0;
    #1;
    check("rst_mid_lines", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    check("rst_mid_busy", busy, 1'b0);
    tick(5);
    reset = 1'b1;
    tick(T_EDGE + 40);
    #1;
    check("rst_mid_no_done", done_cnt, base);
    check("rst_mid_flags", {busy, timeout, ack_err}, 3'b000);

    for (int r = 0; r < 6; r++) begin
      logic [7:0] b;
      int half;
      bit ackl;
      b    = 8'($urandom_range(0, 255));
      half = $urandom_range(6, 30);
      ackl = 1'($urandom_range(0, 1));
      run_frame(b, half, ackl, 1'b0, 0, seen);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter CEFREQ, default 8000000, frequency in Hz of ce strobes; all timing is derived from it.
REQ-002 clock  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 ce  input  1  clock-enable strobe; timers, line sampling and FSM advance only when ce=1.
REQ-005 ps2_clk_i  input  1  PS/2 clock line as seen at the pad (asynchronous).
REQ-006 ps2_dat_i  input  1  PS/2 data line as seen at the pad (asynchronous).
REQ-007 ps2_clk_oe  output  1  1 = drive PS/2 clock low (open-drain), 0 = release.
REQ-008 ps2_dat_oe  output  1  1 = drive PS/2 data low (open-drain), 0 = release.
REQ-009 start  input  1  request to send byte on data; sampled when ce=1.
REQ-010 data  input  8  byte to transmit (e.g. LED command 0xED, argument).
REQ-011 busy  output  1  high from accepted start until return to IDLE.
REQ-012 done  output  1  single clock-cycle pulse at end of every transaction.
REQ-013 ack_err  output  1  valid with done: device did not acknowledge.
REQ-014 timeout  output  1  valid with done: device clock watchdog expired.

Function
REQ-015 Both pad inputs SHALL pass a 2-flop synchronizer on clock; falling edge of ps2 clock is detected by comparing synchronized samples taken on consecutive ce strobes.
REQ-016 Constants: T_INH = CEFREQ/10000 (100 us), T_FIRST = CEFREQ*15/1000 (15 ms), T_EDGE = CEFREQ/500 (2 ms); counter width fits T_FIRST (17 bits at default).
REQ-017 States: IDLE, INHIBIT, REQ, SHIFT, ACK, RELEASE.
REQ-018 IDLE: start=1 with ce=1 latches data, computes odd parity (~^data), sets busy, clears counter, enters INHIBIT; both oe = 0.
REQ-019 INHIBIT: ps2_clk_oe=1, ps2_dat_oe=0 for T_INH ce ticks; then ps2_dat_oe=1 for one further tick and enter REQ.
REQ-020 REQ: ps2_clk_oe=0, ps2_dat_oe=1 (start bit); on first device falling edge drive bit 0 (ps2_dat_oe = ~data[0]), bit index=1, enter SHIFT.
REQ-021 SHIFT: each falling edge presents next bit: data[1..7], then parity, then stop (ps2_dat_oe=0); after the stop bit is presented enter ACK.
REQ-022 ACK: on next falling edge sample synchronized data; 0 = acknowledged, 1 = ack_err; enter RELEASE.
REQ-023 RELEASE: both oe=0; wait until synchronized clock and data both high, then pulse done for one clock, return IDLE, drop busy the same cycle.
REQ-024 Watchdog: counter reset on every falling edge; if T_FIRST ticks elapse in REQ or T_EDGE ticks in SHIFT/ACK without an edge, release both lines, set timeout, pulse done, return IDLE.
REQ-025 ack_err and timeout SHALL hold their value from the done pulse until the next accepted start, which clears both.
REQ-026 start while busy is ignored; data is not re-sampled after acceptance.
REQ-027 Bits are presented only on falling edges so data is stable across the device-sampled rising edge.
REQ-028 With ce held low, all state, counters and outputs are frozen.

Reset
REQ-029 reset=0 asynchronously forces IDLE, ps2_clk_oe=0, ps2_dat_oe=0, busy=0, done=0, ack_err=0, timeout=0, counter=0, synchronizers=1.
REQ-030 Reset mid-transaction releases both lines immediately; no done pulse is produced.

Verification
REQ-031 Send 0xED, device model clocks 11 falling edges and pulls data low on the 11th -> start bit 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1 observed at rising edges; done pulse, ack_err=0, timeout=0.
REQ-032 Send 0x00 -> parity bit 1; send 0x01 -> parity bit 0; INHIBIT clock-low lasts exactly 800 ce ticks at default CEFREQ.
REQ-033 Device never clocks -> after 120000 ce ticks in REQ: lines released, done pulse, timeout=1, busy=0.
REQ-034 Device stops after 4 edges -> after 16000 ticks: timeout=1; device leaves data high on ACK edge -> ack_err=1.
REQ-035 Assert reset during SHIFT -> both oe=0 and busy=0 same cycle, no done; start during busy -> ignored, original byte completes unchanged.
